// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: single-neuron multiply-accumulate sequencer.
// It reads N input/weight byte pairs from the neuron RAM and accumulates their products.
// The sum is then shifted, saturated to 8 bits and written back to the RAM.
// Optional feature macro: NEURON_MAC_BIAS_EN preloads the accumulator from RAM[BIAS_ADDR].
module neuron_mac_seq #(
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned IN_BASE   = 0,
    parameter int unsigned W_BASE    = 4,
    parameter int unsigned OUT_ADDR  = 8,
    parameter int unsigned BIAS_ADDR = 9,
    parameter int unsigned SHIFT     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] ram_read_address,
    output logic       ram_oe,
    input  logic [7:0] ram_read_data,
    output logic [7:0] ram_write_address,
    output logic [7:0] ram_write_data,
    output logic       ram_wre
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 21;
    localparam int unsigned IDX_W  = 4;

`ifdef NEURON_MAC_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    // First read address after start: the bias byte if present, else input 0
    localparam logic [ADDR_W-1:0] FIRST_ADDR = BIAS_EN ? ADDR_W'(BIAS_ADDR) : ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] OUT_A      = ADDR_W'(OUT_ADDR);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0]  SAT_MAX    = ACC_W'(255);

`ifdef NEURON_MAC_BIAS_EN
    typedef enum logic [2:0] {
        S_IDLE, S_RD_B, S_RD_X, S_RD_W, S_WRITE, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_RD_X, S_RD_W, S_WRITE, S_DONE
    } state_t;
`endif

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_x;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_result;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_oe;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wre;

    logic [IDX_W-1:0]    w_idx_inc;
    logic [PROD_W-1:0]   w_prod;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [ACC_W-1:0]    w_shifted;
    logic [DATA_W-1:0]   w_sat;

    // Datapath: product of latched input and current weight, scaled and saturated
    always_comb begin
        w_idx_inc = r_idx + IDX_W'(1);
        w_prod    = PROD_W'(r_x) * PROD_W'(ram_read_data);
        w_acc_sum = r_acc + ACC_W'(w_prod);
        w_shifted = w_acc_sum >> SHIFT;
        w_sat     = (w_shifted > SAT_MAX) ? 8'hFF : w_shifted[DATA_W-1:0];
    end

    // Sequencer FSM; outputs are registered with the values belonging to the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_x       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_rd_addr <= '0;
            r_oe      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wre     <= 1'b0;
        end else begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_rd_addr <= '0;
            r_oe      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wre     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_acc     <= '0;
                        r_oe      <= 1'b1;
                        r_rd_addr <= FIRST_ADDR;
`ifdef NEURON_MAC_BIAS_EN
                        r_state   <= S_RD_B;
`else
                        r_state   <= S_RD_X;
`endif
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
`ifdef NEURON_MAC_BIAS_EN
                S_RD_B: begin
                    r_acc     <= ACC_W'(ram_read_data);
                    r_oe      <= 1'b1;
                    r_rd_addr <= ADDR_W'(IN_BASE);
                    r_state   <= S_RD_X;
                end
`endif
                S_RD_X: begin
                    r_x       <= ram_read_data;
                    r_oe      <= 1'b1;
                    r_rd_addr <= ADDR_W'(W_BASE + 32'(r_idx));
                    r_state   <= S_RD_W;
                end
                S_RD_W: begin
                    r_acc <= w_acc_sum;
                    if (r_idx == LAST_IDX) begin
                        r_wre     <= 1'b1;
                        r_wr_addr <= OUT_A;
                        r_wr_data <= w_sat;
                        r_state   <= S_WRITE;
                    end else begin
                        r_idx     <= w_idx_inc;
                        r_oe      <= 1'b1;
                        r_rd_addr <= ADDR_W'(IN_BASE + 32'(w_idx_inc));
                        r_state   <= S_RD_X;
                    end
                end
                S_WRITE: begin
                    r_result <= r_wr_data;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign result            = r_result;
    assign ram_read_address  = r_rd_addr;
    assign ram_oe            = r_oe;
    assign ram_write_address = r_wr_addr;
    assign ram_write_data    = r_wr_data;
    // Reset in the WRITE cycle must stop the RAM commit at the closing edge
    assign ram_wre           = r_wre & ~rst;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed testbench for neuron_mac_seq.
// Three instances (SHIFT = 0, 2, 12) each own a private RAM model.
// Compile with NEURON_MAC_BIAS_EN to exercise the bias build.
`timescale 1ns/1ps
module tb_neuron_mac_seq;

    localparam int NK = 3;
`ifdef NEURON_MAC_BIAS_EN
    localparam int BIAS_V = 100;
    localparam int LAT    = 11;
`else
    localparam int BIAS_V = 0;
    localparam int LAT    = 10;
`endif
    localparam logic [7:0] EXP_SET1   = 8'(147 + BIAS_V);
    localparam logic [7:0] EXP_SET1_2 = 8'((147 + BIAS_V) >> 2);

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] start, busy, done, oe, wre;
    logic [7:0]    result [NK];
    logic [7:0]    raddr  [NK];
    logic [7:0]    rdata  [NK];
    logic [7:0]    waddr  [NK];
    logic [7:0]    wdata  [NK];
    logic [7:0]    mem    [NK][256];
    int            wr_cnt [NK] = '{0, 0, 0};

    logic          ld_en;
    int            ld_k;
    logic [7:0]    ld_a, ld_d;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        neuron_mac_seq #(
            .N_INPUTS (4),
            .IN_BASE  (0),
            .W_BASE   (4),
            .OUT_ADDR (8),
            .BIAS_ADDR(9),
            .SHIFT    ((g == 0) ? 0 : (g == 1) ? 2 : 12)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .start            (start[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .result           (result[g]),
            .ram_read_address (raddr[g]),
            .ram_oe           (oe[g]),
            .ram_read_data    (rdata[g]),
            .ram_write_address(waddr[g]),
            .ram_write_data   (wdata[g]),
            .ram_wre          (wre[g])
        );
        assign rdata[g] = oe[g] ? mem[g][raddr[g]] : 8'h00;
    end

    // RAM models: registered write port plus bench preload port
    always @(posedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (wre[k]) begin
                mem[k][waddr[k]] <= wdata[k];
                wr_cnt[k]        <= wr_cnt[k] + 1;
            end
        end
        if (ld_en) mem[ld_k][ld_a] <= ld_d;
    end

    task automatic poke(input int k, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_k = k; ld_a = a; ld_d = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // xs/ws hold bytes 0..3 in ascending byte lanes; also sets bias=100 and a marker at RAM[8]
    task automatic load_set(input int k, input logic [31:0] xs, input logic [31:0] ws,
                            input logic [7:0] marker);
        for (int i = 0; i < 4; i++) begin
            poke(k, 8'(i), xs[8*i +: 8]);
            poke(k, 8'(4 + i), ws[8*i +: 8]);
        end
        poke(k, 8'd9, 8'd100);
        poke(k, 8'd8, marker);
    endtask

    // One start pulse; lat = cycle index of done (cycle 1 follows the start edge), -1 on timeout
    task automatic run_once(input int k, output int lat, output int nbusy);
        lat = -1; nbusy = 0;
        @(negedge clk); start[k] = 1'b1;
        @(posedge clk); #1; start[k] = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done[k]) begin lat = n; break; end
            if (busy[k]) nbusy++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        vectors++; if (done[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done[0]); end
        vectors++; if (result[0] !== 8'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result[0]); end
        vectors++; if (oe[0] !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", oe[0]); end
        vectors++; if (wre[0] !== 1'b0) begin errors++; $display("FAIL reset_wre: got %b want 0", wre[0]); end
        vectors++; if (raddr[0] !== 8'd0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", raddr[0]); end
        vectors++; if (waddr[0] !== 8'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", waddr[0]); end
        vectors++; if (wdata[0] !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %0d want 0", wdata[0]); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, nb, w0;
        for (int k = 0; k < 2; k++) load_set(k, 32'h0B0A_0B0A, 32'h0203_0504, 8'hAA);
        w0 = wr_cnt[0];
        run_once(0, lat, nb);
        vectors++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        vectors++; if (nb !== LAT - 1) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", nb, LAT - 1); end
        vectors++; if (mem[0][8] !== EXP_SET1) begin errors++; $display("FAIL basic_ram8: got %0d want %0d", mem[0][8], EXP_SET1); end
        vectors++; if (result[0] !== EXP_SET1) begin errors++; $display("FAIL basic_result: got %0d want %0d", result[0], EXP_SET1); end
        vectors++; if (wr_cnt[0] - w0 !== 1) begin errors++; $display("FAIL basic_write_count: got %0d want 1", wr_cnt[0] - w0); end
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy[0]); end
        run_once(1, lat, nb);
        vectors++; if (mem[1][8] !== EXP_SET1_2) begin errors++; $display("FAIL shift2_ram8: got %0d want %0d", mem[1][8], EXP_SET1_2); end
        vectors++; if (result[1] !== EXP_SET1_2) begin errors++; $display("FAIL shift2_result: got %0d want %0d", result[1], EXP_SET1_2); end
    endtask

    task automatic test_saturate;
        int lat, nb;
        load_set(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00);
        load_set(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00);
        run_once(0, lat, nb);
        vectors++; if (mem[0][8] !== 8'd255) begin errors++; $display("FAIL sat_ram8: got %0d want 255", mem[0][8]); end
        run_once(2, lat, nb);
        vectors++; if (mem[2][8] !== 8'd63) begin errors++; $display("FAIL shift12_ram8: got %0d want 63", mem[2][8]); end
        vectors++; if (result[2] !== 8'd63) begin errors++; $display("FAIL shift12_result: got %0d want 63", result[2]); end
    endtask

    task automatic test_reset_mid;
        int w0, nd;
        load_set(0, 32'h0B0A_0B0A, 32'h0203_0504, 8'h5A);
        w0 = wr_cnt[0];
        // Reset during the first read cycle
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstA_busy: got %b want 0", busy[0]); end
        vectors++; if (oe[0] !== 1'b0) begin errors++; $display("FAIL rstA_oe: got %b want 0", oe[0]); end
        vectors++; if (raddr[0] !== 8'd0) begin errors++; $display("FAIL rstA_raddr: got %0d want 0", raddr[0]); end
        vectors++; if (result[0] !== 8'd0) begin errors++; $display("FAIL rstA_result: got %0d want 0", result[0]); end
        rst = 1'b0;
        nd = 0;
        for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (done[0]) nd++; end
        vectors++; if (nd !== 0) begin errors++; $display("FAIL rstA_no_done: got %0d pulses want 0", nd); end
        // Reset in the WRITE cycle
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (LAT - 2) @(posedge clk);
        #1;
        vectors++; if (wre[0] !== 1'b1) begin errors++; $display("FAIL rstB_write_cycle_wre: got %b want 1", wre[0]); end
        vectors++; if (waddr[0] !== 8'd8) begin errors++; $display("FAIL rstB_write_cycle_waddr: got %0d want 8", waddr[0]); end
        vectors++; if (wdata[0] !== EXP_SET1) begin errors++; $display("FAIL rstB_write_cycle_wdata: got %0d want %0d", wdata[0], EXP_SET1); end
        rst = 1'b1; #1;
        vectors++; if (wre[0] !== 1'b0) begin errors++; $display("FAIL rstB_wre_forced: got %b want 0", wre[0]); end
        @(posedge clk); #1;
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstB_busy: got %b want 0", busy[0]); end
        vectors++; if (done[0] !== 1'b0) begin errors++; $display("FAIL rstB_done: got %b want 0", done[0]); end
        vectors++; if (wdata[0] !== 8'd0) begin errors++; $display("FAIL rstB_wdata: got %0d want 0", wdata[0]); end
        vectors++; if (result[0] !== 8'd0) begin errors++; $display("FAIL rstB_result: got %0d want 0", result[0]); end
        rst = 1'b0;
        nd = 0;
        for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (done[0]) nd++; end
        vectors++; if (nd !== 0) begin errors++; $display("FAIL rstB_no_done: got %0d pulses want 0", nd); end
        vectors++; if (mem[0][8] !== 8'h5A) begin errors++; $display("FAIL rst_ram8_kept: got %0d want 90", mem[0][8]); end
        vectors++; if (wr_cnt[0] - w0 !== 0) begin errors++; $display("FAIL rst_write_count: got %0d want 0", wr_cnt[0] - w0); end
    endtask

    task automatic test_start_ignored;
        int first, nd;
        first = -1; nd = 0;
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        for (int n = 1; n <= LAT + 20; n++) begin
            start[0] = (n == 3 || n == 6);
            if (done[0]) begin
                nd++;
                if (first < 0) first = n;
            end
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        vectors++; if (first !== LAT) begin errors++; $display("FAIL ignore_first_done: got %0d want %0d", first, LAT); end
        vectors++; if (nd !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
        vectors++; if (mem[0][8] !== EXP_SET1) begin errors++; $display("FAIL ignore_ram8: got %0d want %0d", mem[0][8], EXP_SET1); end
    endtask

    task automatic test_back_to_back;
        int d1, d2, w0;
        d1 = -1; d2 = -1;
        poke(0, 8'd8, 8'h00);
        w0 = wr_cnt[0];
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 3 * LAT; n++) begin
            if (done[0]) begin
                if (d1 < 0) d1 = n;
                else begin d2 = n; start[0] = 1'b0; break; end
            end
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        repeat (LAT + 5) @(posedge clk);
        #1;
        vectors++; if (d1 !== LAT) begin errors++; $display("FAIL b2b_first_done: got %0d want %0d", d1, LAT); end
        vectors++; if (d2 - d1 !== LAT + 1) begin errors++; $display("FAIL b2b_period: got %0d want %0d", d2 - d1, LAT + 1); end
        vectors++; if (wr_cnt[0] - w0 !== 2) begin errors++; $display("FAIL b2b_write_count: got %0d want 2", wr_cnt[0] - w0); end
        vectors++; if (mem[0][8] !== EXP_SET1) begin errors++; $display("FAIL b2b_ram8: got %0d want %0d", mem[0][8], EXP_SET1); end
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b want 0", busy[0]); end
    endtask

    initial begin
        rst = 1'b1; start = '0; ld_en = 1'b0; ld_k = 0; ld_a = '0; ld_d = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequencer that computes one neuron output from the shared neuron dual-port RAM. On a start pulse it reads N input/weight byte pairs over the RAM read port, multiply-accumulates them, scales and saturates the sum to 8 bits, and writes the result back through the RAM write port. It sits directly in front of the RAM and is its only master; the RAM read port is combinational and the write port is registered on `clk`.

## Interface
- `N_INPUTS`, default 4: number of input/weight pairs, 1..16.
- `IN_BASE`, default 0: RAM address of input 0; input i is at `IN_BASE+i`.
- `W_BASE`, default 4: RAM address of weight 0; weight i is at `W_BASE+i`.
- `OUT_ADDR`, default 8: RAM address the result is written to.
- `BIAS_ADDR`, default 9: RAM address of the bias byte, used only with the bias feature.
- `SHIFT`, default 0: right shift applied to the accumulator before saturation, 0..12.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `busy`  out  1  high from the accepting edge until the return to IDLE.
- `done`  out  1  one-cycle pulse; the result is committed to RAM.
- `result`  out  8  last written value; held until the next write.
- `ram_read_address`  out  8  drives the RAM read address.
- `ram_oe`  out  1  RAM output enable.
- `ram_read_data`  in  8  RAM read data, valid in the same cycle.
- `ram_write_address`  out  8  RAM write address.
- `ram_write_data`  out  8  RAM write data.
- `ram_wre`  out  1  RAM write enable.

## Operation
- States: IDLE, RD_X, RD_W, WRITE, DONE, plus RD_B when the bias feature is compiled in.
- IDLE: `ram_oe`=0, `ram_wre`=0, all addresses 0. If `start`=1, clear the accumulator and index i, then go to RD_X (or RD_B).
- RD_B: address `BIAS_ADDR`, `ram_oe`=1; acc ← zero-extended `ram_read_data`; go to RD_X.
- RD_X: address `IN_BASE+i`, `ram_oe`=1; x_reg ← `ram_read_data`; go to RD_W.
- RD_W: address `W_BASE+i`, `ram_oe`=1; acc ← acc + x_reg×`ram_read_data` (unsigned 8×8→16). If i=`N_INPUTS`−1, go to WRITE; otherwise i←i+1 and go to RD_X.
- WRITE: `ram_wre`=1, `ram_write_address`=`OUT_ADDR`, `ram_write_data`=sat(acc>>`SHIFT`); the `result` register loads the same value; go to DONE.
- DONE: `done`=1; go to IDLE.
- Arithmetic: the accumulator is 21 bits unsigned and cannot overflow for N≤16 plus bias. sat(v) = v if v≤255, else 255.
- `start` outside IDLE is ignored and not queued. `start` held high through DONE starts a new run on the first IDLE cycle.
- Address sums are taken modulo 256.

## Timing
- Start accepted at edge E0. Without bias: RD_X/RD_W occupy cycles 1..2N, WRITE is cycle 2N+1 (the RAM commits at edge E(2N+1)), and DONE is cycle 2N+2. Latency from start to done is 2N+2 cycles; N=4 gives 10.
- With bias, one extra cycle: 2N+3.
- Back-to-back throughput: one result every 2N+3 cycles (2N+4 with bias), because one IDLE cycle is mandatory between runs.
- `busy` is high in every non-IDLE state. `done` is never high in the same cycle as `ram_wre`.
- All control outputs are Moore outputs decoded from state and index only. Read data is used combinationally within the same cycle.
- Reset values: `busy`=0, `done`=0, `result`=0, `ram_oe`=0, `ram_wre`=0, all addresses 0, `ram_write_data`=0. State returns to IDLE, and acc, x_reg and i are cleared.
- Reset mid-run: reset takes priority over every transition. If `rst` is high in the WRITE cycle, no RAM write occurs because `ram_wre` is forced low; no `done` pulse follows.

## Configuration
- `NEURON_MAC_BIAS_EN` defined: the RD_B state exists, the accumulator is preloaded with the RAM byte at `BIAS_ADDR`, and latency is 2N+3.
- `NEURON_MAC_BIAS_EN` undefined: there is no RD_B state, the accumulator starts at 0, latency is 2N+2, and `BIAS_ADDR` is unused.

## Test plan
- RAM[0..3]=10,11,10,11, RAM[4..7]=4,5,3,2, N=4, SHIFT=0, start pulse → RAM[8]=147, `result`=147, `done` exactly 10 cycles after the start edge, `busy` high for 9 cycles.
- Same data with SHIFT=2 → RAM[8]=36.
- All inputs and weights 255, SHIFT=0 → RAM[8]=255 (saturated); with SHIFT=12 → 63.
- Bias build, first data set, RAM[9]=100 → RAM[8]=247, `done` 11 cycles after start.
- `rst` asserted in the cycle after start, and separately in the WRITE cycle → no RAM write, RAM[8] unchanged, all outputs at reset values the next cycle, no `done`.
- `start` pulses during busy → ignored. `start` held high → back-to-back runs with `done` pulses 11 cycles apart.
